// File: rtl/fetch_sequencer_if.sv
// Fetch-to-core/memory/decode signal bundle for fetch_sequencer.
// master = fetch_sequencer side, slave = core control / program memory / decode side.
interface fetch_sequencer_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32
);
    logic               start_i;
    logic               halt_i;
    logic               redirect_i;
    logic [ADDR_W-1:0]  redirect_pc_i;
    logic [ADDR_W-1:0]  mem_addr_o;
    logic [INSTR_W-1:0] mem_instr_i;
    logic               instr_valid_o;
    logic [INSTR_W-1:0] instr_o;
    logic [ADDR_W-1:0]  instr_pc_o;
    logic               instr_ready_i;
    logic               running_o;
    logic               fault_o;

    modport master (
        input  start_i, halt_i, redirect_i, redirect_pc_i, mem_instr_i, instr_ready_i,
        output mem_addr_o, instr_valid_o, instr_o, instr_pc_o, running_o, fault_o
    );

    modport slave (
        output start_i, halt_i, redirect_i, redirect_pc_i, mem_instr_i, instr_ready_i,
        input  mem_addr_o, instr_valid_o, instr_o, instr_pc_o, running_o, fault_o
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the PC, reads a combinational program memory and
// holds one fetched word for decode. FETCH_ALIGN_CHECK_EN enables the misaligned-redirect fault.
module fetch_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fetch_sequencer_if.master  bus
);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
`endif

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  pc_reg, pc_next;
    logic               valid_reg, valid_next;
    logic [INSTR_W-1:0] instr_reg, instr_next;
    logic [ADDR_W-1:0]  ipc_reg, ipc_next;
    logic               transfer;
    logic               load;
`ifdef FETCH_ALIGN_CHECK_EN
    logic               fault_reg, fault_next;
    logic               misaligned;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            valid_reg <= 1'b0;
            instr_reg <= '0;
            ipc_reg   <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            valid_reg <= valid_next;
            instr_reg <= instr_next;
            ipc_reg   <= ipc_next;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_reg <= fault_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        valid_next = valid_reg;
        instr_next = instr_reg;
        ipc_next   = ipc_reg;
        transfer   = valid_reg && bus.instr_ready_i;
        // A redirect or halt suppresses the fetch in the cycle it arrives.
        load       = (state_reg == RUN) && !bus.halt_i && !bus.redirect_i &&
                     (!valid_reg || bus.instr_ready_i);
`ifdef FETCH_ALIGN_CHECK_EN
        fault_next = fault_reg;
        misaligned = bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00);
`endif

        case (state_reg)
            IDLE, HALT: begin
                if (transfer)
                    valid_next = 1'b0;
                if (bus.start_i)
                    state_next = RUN;
            end
            RUN: begin
                if (bus.halt_i) begin
                    state_next = HALT;
                    if (transfer)
                        valid_next = 1'b0;
                end else if (load) begin
                    instr_next = bus.mem_instr_i;
                    ipc_next   = pc_reg;
                    valid_next = 1'b1;
                    pc_next    = pc_reg + ADDR_W'(4);
                end
            end
            default: ;
        endcase

`ifdef FETCH_ALIGN_CHECK_EN
        if (state_reg != FAULT) begin
            if (misaligned) begin
                state_next = FAULT;
                fault_next = 1'b1;
                valid_next = 1'b0;
                pc_next    = pc_reg;
            end else if (bus.redirect_i) begin
                pc_next    = bus.redirect_pc_i;
                valid_next = 1'b0;
            end
        end
`else
        if (bus.redirect_i) begin
            pc_next    = bus.redirect_pc_i;
            valid_next = 1'b0;
        end
`endif
    end

    assign bus.mem_addr_o    = pc_reg;
    assign bus.instr_valid_o = valid_reg;
    assign bus.instr_o       = instr_reg;
    assign bus.instr_pc_o    = ipc_reg;
    assign bus.running_o     = (state_reg == RUN);
`ifdef FETCH_ALIGN_CHECK_EN
    assign bus.fault_o       = fault_reg;
`else
    assign bus.fault_o       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed vector bench for fetch_sequencer with a byte-array program memory model.
// Expectations follow FETCH_ALIGN_CHECK_EN the same way the design does.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_W(8), .INSTR_W(32)) bus ();

    fetch_sequencer #(.ADDR_W(8), .INSTR_W(32), .RESET_PC(8'h00)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [7:0] mem [256];
    assign bus.mem_instr_i = {mem[8'(bus.mem_addr_o + 8'd3)], mem[8'(bus.mem_addr_o + 8'd2)],
                              mem[8'(bus.mem_addr_o + 8'd1)], mem[bus.mem_addr_o]};

    typedef struct {
        logic        start, halt, redirect;
        logic [7:0]  rpc;
        logic        ready;
        logic        valid;
        logic [31:0] instr;
        logic [7:0]  ipc;
        logic [7:0]  addr;
        logic        run;
        logic        flt;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(logic s, logic h, logic r, logic [7:0] rpc, logic rdy,
                                logic v, logic [31:0] ins, logic [7:0] ipc,
                                logic [7:0] addr, logic run, logic flt);
        vec_t x;
        x.start = s; x.halt = h; x.redirect = r; x.rpc = rpc; x.ready = rdy;
        x.valid = v; x.instr = ins; x.ipc = ipc; x.addr = addr; x.run = run; x.flt = flt;
        return x;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic v, logic [31:0] ins, logic [7:0] ipc,
                           logic [7:0] addr, logic run, logic flt);
        chk({tag, ".valid"},   32'(bus.instr_valid_o), 32'(v));
        chk({tag, ".instr"},   bus.instr_o,            ins);
        chk({tag, ".pc"},      32'(bus.instr_pc_o),    32'(ipc));
        chk({tag, ".addr"},    32'(bus.mem_addr_o),    32'(addr));
        chk({tag, ".running"}, 32'(bus.running_o),     32'(run));
        chk({tag, ".fault"},   32'(bus.fault_o),       32'(flt));
    endtask

    localparam logic [31:0] W00 = 32'h00000013;
    localparam logic [31:0] W04 = 32'h00100093;
    localparam logic [31:0] W08 = 32'h00200113;
    localparam logic [31:0] WFC = 32'hFAF3ECE5;
    localparam logic [31:0] W20 = 32'hF6EFE8E1;
    localparam logic [31:0] W06 = 32'h01130010;

    initial begin
        logic [7:0] prog [12];
        int n;
        prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 1);
        for (int i = 0; i < 12; i++) mem[i] = prog[i];

        //             s  h  r  rpc    rdy  v  instr ipc    addr   run flt
        for (int i = 0; i < 4; i++)
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0,   8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'h00, 1, 0, 0,   8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 0, 0,   8'h00, 8'h00, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, W00, 8'h00, 8'h04, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, W04, 8'h04, 8'h08, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, W08, 8'h08, 8'h0C, 1, 0));
        vecs.push_back(mk(0, 0, 1, 8'h00, 1, 0, W08, 8'h08, 8'h00, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, W00, 8'h00, 8'h04, 1, 0));
        for (int i = 0; i < 3; i++)
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1, W00, 8'h00, 8'h04, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, W04, 8'h04, 8'h08, 1, 0));
        vecs.push_back(mk(0, 0, 1, 8'hFC, 1, 0, W04, 8'h04, 8'hFC, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, WFC, 8'hFC, 8'h00, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, W00, 8'h00, 8'h04, 1, 0));
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 1, W00, 8'h00, 8'h04, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1, W00, 8'h00, 8'h04, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, W00, 8'h00, 8'h04, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, W00, 8'h00, 8'h04, 0, 0));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 0, W00, 8'h00, 8'h04, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, W04, 8'h04, 8'h08, 1, 0));
        vecs.push_back(mk(0, 1, 1, 8'h20, 1, 0, W04, 8'h04, 8'h20, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h00, 1, 0, W04, 8'h04, 8'h20, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, W20, 8'h20, 8'h24, 1, 0));
        vecs.push_back(mk(0, 1, 0, 8'h00, 1, 0, W20, 8'h20, 8'h24, 0, 0));
`ifdef FETCH_ALIGN_CHECK_EN
        vecs.push_back(mk(0, 0, 1, 8'h06, 1, 0, W20, 8'h20, 8'h24, 0, 1));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 0, W20, 8'h20, 8'h24, 0, 1));
        vecs.push_back(mk(0, 0, 1, 8'h40, 1, 0, W20, 8'h20, 8'h24, 0, 1));
`else
        vecs.push_back(mk(0, 0, 1, 8'h06, 1, 0, W20, 8'h20, 8'h06, 0, 0));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 0, W20, 8'h20, 8'h06, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, W06, 8'h06, 8'h0A, 1, 0));
`endif

        bus.start_i = 0; bus.halt_i = 0; bus.redirect_i = 0;
        bus.redirect_pc_i = 8'h00; bus.instr_ready_i = 0;

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 8'h00, 8'h00, 0, 0);
        $display("reset: valid=%b addr=%h run=%b", bus.instr_valid_o, bus.mem_addr_o, bus.running_o);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            bus.start_i       = vecs[i].start;
            bus.halt_i        = vecs[i].halt;
            bus.redirect_i    = vecs[i].redirect;
            bus.redirect_pc_i = vecs[i].rpc;
            bus.instr_ready_i = vecs[i].ready;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].valid, vecs[i].instr, vecs[i].ipc,
                    vecs[i].addr, vecs[i].run, vecs[i].flt);
            $display("vec %0d: valid=%b instr=%h pc=%h addr=%h run=%b fault=%b", i,
                     bus.instr_valid_o, bus.instr_o, bus.instr_pc_o, bus.mem_addr_o,
                     bus.running_o, bus.fault_o);
        end

        // Asynchronous reset between edges discards everything immediately.
        @(negedge clk);
        bus.start_i = 0; bus.halt_i = 0; bus.redirect_i = 0; bus.instr_ready_i = 1;
        #2;
        rst = 1;
        #1;
        chk_all("async_rst", 0, 0, 8'h00, 8'h00, 0, 0);
        $display("async reset: valid=%b addr=%h fault=%b", bus.instr_valid_o, bus.mem_addr_o, bus.fault_o);
        @(negedge clk);
        rst = 0;

        // Restart: running one cycle after start, first instruction the cycle after.
        @(negedge clk);
        bus.start_i = 1;
        @(posedge clk);
        #1;
        chk("restart.running", 32'(bus.running_o), 32'd1);
        chk("restart.valid_early", 32'(bus.instr_valid_o), 32'd0);
        @(negedge clk);
        bus.start_i = 0;
        n = 0;
        while (!bus.instr_valid_o && n < 4) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("restart.latency", 32'(n), 32'd1);
        chk("restart.pc", 32'(bus.instr_pc_o), 32'h00);
        chk("restart.instr", bus.instr_o, W00);
        $display("restart: latency=%0d pc=%h instr=%h", n, bus.instr_pc_o, bus.instr_o);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch controller that sequences the byte-addressed, combinational program memory (8-bit address, 32-bit little-endian word, read in the same cycle). It owns the program counter and drives the memory address. It registers each fetched word into a one-entry output slot with a valid/ready handshake towards decode. It accepts redirects (jumps/branches), halt and start commands from the core control logic.

## Interface
- ADDR_W, 8, program counter / memory address width
- INSTR_W, 32, instruction width
- RESET_PC, 8'h00, PC value loaded on reset
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  asynchronous, active-high reset
- start_i  input  1  leave IDLE/HALT and begin fetching at current PC
- halt_i  input  1  stop issuing new fetches
- redirect_i  input  1  replace PC and flush output slot
- redirect_pc_i  input  ADDR_W  redirect target byte address
- mem_addr_o  output  ADDR_W  address to program memory (= PC, combinational)
- mem_instr_i  input  INSTR_W  word returned by program memory, same cycle
- instr_valid_o  output  1  output slot holds an instruction
- instr_o  output  INSTR_W  registered instruction
- instr_pc_o  output  ADDR_W  byte address instr_o was fetched from
- instr_ready_i  input  1  decode accepts instr_o this cycle
- running_o  output  1  state == RUN
- fault_o  output  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- States: IDLE, RUN, HALT, FAULT (FAULT reachable only with macro).
- Reset: state=IDLE, PC=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0, fault_o=0, running_o=0.
- IDLE/HALT: no fetch; start_i -> RUN next cycle. halt_i ignored.
- RUN, slot load condition: !instr_valid_o || instr_ready_i. When met: instr_o<=mem_instr_i, instr_pc_o<=PC, instr_valid_o<=1, PC<=PC+4. Otherwise slot and PC hold (backpressure, instr_o stable).
- RUN, accept without load impossible: ready with slot full always reloads.
- PC arithmetic modulo 2^ADDR_W: 8'hFC+4 = 8'h00; no flag.
- redirect_i (any state except FAULT), highest priority: PC<=redirect_pc_i, instr_valid_o<=0, no load that cycle; state unchanged unless halt_i also asserted.
- halt_i in RUN: state->HALT, no load that cycle; a valid slot is held until instr_ready_i, then clears.
- halt_i and redirect_i together in RUN: PC updated, slot flushed, state->HALT.
- start_i and halt_i together in IDLE/HALT: start wins -> RUN.
- Reset mid-operation: immediate return to reset values regardless of handshake state; slot contents discarded.

## Timing
- mem_addr_o is PC combinationally; memory read and capture occur in the same cycle.
- start_i at cycle N -> running_o at N+1, first instr_valid_o at N+2 (pc=RESET_PC).
- Sustained throughput: one instruction per cycle while instr_ready_i=1.
- redirect_i at N -> instr_valid_o=0 at N+1, target instruction valid at N+2.
- Handshake transfer occurs when instr_valid_o && instr_ready_i at a rising edge.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc_i[1:0]!=0 sets fault_o=1 (sticky), state->FAULT, instr_valid_o<=0, PC unchanged; FAULT ignores all inputs; only rst_i exits.
- Undefined: misaligned targets are used as-is (byte-granular fetch), fault_o tied 0, FAULT state absent.

## Test plan
- Reset then idle 5 cycles -> all outputs 0, mem_addr_o=8'h00, running_o=0.
- Memory bytes 00..0B = 13 00 00 00 93 00 10 00 13 01 20 00, start_i pulse, ready=1 -> instr_o 32'h00000013, 32'h00100093, 32'h00200113 on consecutive cycles, instr_pc_o 00,04,08.
- Ready low 3 cycles after first valid -> instr_o/instr_pc_o stable, PC stays 8'h04; ready high -> next word at pc 8'h04.
- Redirect to 8'hFC while running -> valid drops one cycle, instr_pc_o 8'hFC, then 8'h00 (wrap).
- halt_i with full slot and ready low -> running_o=0, slot held; ready -> slot clears; start_i resumes at saved PC.
- With FETCH_ALIGN_CHECK_EN: redirect to 8'h06 -> fault_o=1 next cycle, no further valids despite start_i; rst_i clears fault_o. Without the macro, the same stimulus yields instr_pc_o=8'h06 and fault_o=0.
